// File: rtl/imem_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_access_arbiter: shares the instruction memory between CPU fetches   |
// | and a program loader. Optional macro: IMEM_ARB_FAIRNESS_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module imem_access_arbiter #(
  parameter int ADDR_BITS = 7,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_req,
  input  logic [31:0]          fetch_addr,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_data,
  output logic                 fetch_err,
  output logic                 cpu_stall,
  input  logic                 load_req,
  input  logic                 load_valid,
  input  logic [31:0]          load_addr,
  input  logic [31:0]          load_data,
  output logic                 load_ready,
  output logic [ADDR_BITS:0]   load_count,
  output logic                 load_err,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_t;

  localparam logic [ADDR_BITS:0] COUNT_MAX = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] COUNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   ready_nxt;
  logic   take_fetch;
  logic   start_load;
  logic   set_resume;
  logic   resume;
  logic   rd_misalign;
  logic   preempt;
  logic   hs_ok;
  logic   hs_bad;

  assign hs_ok     = load_valid & load_ready & (load_addr[1:0] == 2'b00);
  assign hs_bad    = load_valid & load_ready & (load_addr[1:0] != 2'b00);
  assign mem_re    = (state == RD);
  assign cpu_stall = fetch_req & ~fetch_valid;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:ADDR_BITS+2], load_addr[31:ADDR_BITS+2]};

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int                 BURST_W     = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE   = BURST_W'(1);

  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_nxt;

  assign burst_nxt = (hs_ok && burst_cnt != BURST_LIMIT) ? burst_cnt + BURST_ONE : burst_cnt;
  assign preempt   = fetch_req & (burst_nxt == BURST_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (start_load) begin
      burst_cnt <= '0;
    end else begin
      burst_cnt <= burst_nxt;
    end
  end
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
  assign preempt          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ready_nxt  = load_ready;
    take_fetch = 1'b0;
    start_load = 1'b0;
    set_resume = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_nxt  = LOAD;
          ready_nxt  = 1'b1;
          start_load = 1'b1;
        end else if (fetch_req) begin
          state_nxt  = RD;
          take_fetch = 1'b1;
        end
      end
      RD:   state_nxt = WAIT;
      WAIT: state_nxt = IDLE;
      LOAD: begin
        // Not ready while in LOAD only happens in the drain cycle after a preemption.
        if (!load_ready) begin
          if (fetch_req) begin
            state_nxt  = RD;
            take_fetch = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!load_req) begin
          state_nxt = IDLE;
          ready_nxt = 1'b0;
        end else if (preempt) begin
          ready_nxt  = 1'b0;
          set_resume = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_misalign <= 1'b0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_count  <= '0;
      load_err    <= 1'b0;
      resume      <= 1'b0;
    end else begin
      load_ready <= ready_nxt;
      mem_we     <= hs_ok;
      if (hs_ok) begin
        mem_addr  <= load_addr[ADDR_BITS+1:2];
        mem_wdata <= load_data;
      end else if (take_fetch) begin
        mem_addr <= fetch_addr[ADDR_BITS+1:2];
      end
      if (take_fetch) begin
        rd_misalign <= (fetch_addr[1:0] != 2'b00);
      end
      if (state == WAIT) begin
        fetch_data <= mem_rdata;
      end
      fetch_valid <= (state == WAIT);
      fetch_err   <= (state == WAIT) & rd_misalign;
      // A resumed grant continues the interrupted session's statistics.
      if (start_load && !resume) begin
        load_count <= '0;
        load_err   <= 1'b0;
      end else begin
        if (hs_ok && load_count != COUNT_MAX) begin
          load_count <= load_count + COUNT_ONE;
        end
        if (hs_bad) begin
          load_err <= 1'b1;
        end
      end
      if (set_resume) begin
        resume <= 1'b1;
      end else if (state == IDLE) begin
        resume <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_access_arbiter.md
# imem_access_arbiter

Sequencer and arbiter for the 128-word instruction memory in the single-cycle MIPS design. It shares the memory between the CPU fetch path (read-only) and a program loader (word writes), and drives the memory's address, read-enable and write port. Fetches return through a fixed-latency request/valid handshake. The loader streams words through a valid/ready handshake while it owns the memory.

## Interface
- ADDR_BITS, 7, word-index width; memory depth is 2^ADDR_BITS words
- MAX_BURST, 16, loader words per grant before a pending fetch may preempt (used only with IMEM_ARB_FAIRNESS_EN)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  CPU fetch request; held high until fetch_valid
- fetch_addr  in  32  byte address; latched when the request is accepted
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid
- fetch_data  out  32  fetched instruction, registered
- fetch_err  out  1  pulses with fetch_valid when the latched fetch_addr[1:0] != 0
- cpu_stall  out  1  fetch_req & ~fetch_valid (combinational)
- load_req  in  1  loader requests memory ownership
- load_valid  in  1  load_addr and load_data are valid
- load_addr  in  32  byte address of the word to write
- load_data  in  32  word to write
- load_ready  out  1  high, registered, while the loader is granted
- load_count  out  ADDR_BITS+1  words written in the current load session; saturates at 2^ADDR_BITS
- load_err  out  1  sticky; set when a misaligned load word is dropped
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_BITS  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_re

## Operation
- FSM states: IDLE, RD, WAIT, LOAD.
- IDLE:
  - If load_req is high, go to LOAD. The loader has priority.
  - Otherwise, if fetch_req is high, go to RD and latch index = fetch_addr[ADDR_BITS+1:2] and the misalign flag.
- RD: drive mem_re=1 with mem_addr = latched index; go to WAIT.
- WAIT: capture mem_rdata into fetch_data; next cycle fetch_valid=1 (and fetch_err if misaligned); return to IDLE.
  - If fetch_req is still high in IDLE, it is a new request.
- LOAD: load_ready=1.
  - On each cycle with load_valid & load_ready and load_addr[1:0]==0: the next cycle drives mem_we=1, mem_addr = load_addr[ADDR_BITS+1:2], mem_wdata = load_data, and load_count increments.
  - If load_addr[1:0] != 0: the word is dropped and load_err is set.
- LOAD exit: when load_req is low, load_ready drops next cycle; the last issued write completes; return to IDLE.
- Address bits above ADDR_BITS+1 are ignored, so indices wrap modulo 2^ADDR_BITS.
- load_count and load_err clear on an IDLE→LOAD transition that starts a new session, i.e. not a resume after preemption.
- mem_re and mem_we are never high in the same cycle. mem_we, mem_addr and mem_wdata are registered.
- A fetch in progress (RD/WAIT) always completes before LOAD is entered.

## Timing
- Reset: state IDLE; every output 0 (fetch_data, mem_addr, mem_wdata, load_count all zero).
- Reset asserted mid-operation aborts immediately. Any pending write is lost and no fetch_valid is produced.
- Fetch latency: request sampled at edge E (IDLE), mem_re high in cycle E..E+1, fetch_valid high in cycle E+2..E+3. That is 3 cycles when uncontended.
- Load throughput: one word per cycle while granted. The write appears on the memory port one cycle after the handshake.
- Simultaneous load_req and fetch_req in IDLE: LOAD wins; cpu_stall stays high.
- load_count saturates at 2^ADDR_BITS; further writes still occur.

## Configuration
- IMEM_ARB_FAIRNESS_EN defined:
  - A per-grant burst counter counts accepted writes.
  - When it reaches MAX_BURST while fetch_req is high, load_ready drops after the last accepted word and its write issues.
  - The FSM then goes LOAD→RD to serve one fetch, then IDLE→LOAD if load_req is still high. This resume keeps load_count and load_err.
  - The burst counter resets on every entry to LOAD.
- Undefined: the loader has strict priority for the whole time load_req is high, and fetches starve.

## Test plan
- Reset, then fetch_req with fetch_addr=0x0000_0010 -> mem_re with mem_addr=4; fetch_valid 3 cycles after acceptance; fetch_data = word 4; fetch_err=0.
- Loader writes 0xDEADBEEF @0x8, 0x12345678 @0xC -> mem_we pulses at idx 2 and 3 with matching wdata; load_count=2; a following fetch @0xC returns 0x12345678.
- Simultaneous fetch_req and load_req with 3 words -> LOAD first, cpu_stall high throughout; the fetch is served after load_req falls.
- load_addr=0x6 and fetch_addr=0x202 -> word dropped, load_err=1; fetch reads idx 0 (wrap) with fetch_err pulse.
- With IMEM_ARB_FAIRNESS_EN, 40 back-to-back words and fetch_req held -> load_ready drops after word 16, one fetch is served, loading resumes with load_count=16 continuing; without the macro, the fetch waits until all 40 are written.
- rst_n asserted during WAIT -> no fetch_valid; all outputs 0; FSM restarts cleanly.
